// File: rtl/camera_cfg_pkg.sv
// Shared types and widths for the camera register configuration sequencer.
package camera_cfg_pkg;

    localparam int unsigned REG_W   = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ENTRY_W = REG_W + DATA_W;
    localparam int unsigned IDX_W   = 5;

    localparam logic [7:0] SLAVE_ADDR_DEFAULT = 8'hBA;

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        LOAD,
        ISSUE,
        WAIT_END,
        CHECK,
        GAP,
        DONE
    } cfg_state_e;

    typedef struct packed {
        logic [REG_W-1:0]  reg_addr;
        logic [DATA_W-1:0] data;
    } cfg_entry_t;

endpackage

// File: rtl/camera_config_rom.sv
// Combinational register/value table for sensor bring-up; indices past the table read as zero.
module camera_config_rom
    import camera_cfg_pkg::*;
#(
    parameter int unsigned LUT_SIZE = 24
) (
    input  logic [IDX_W-1:0] idx,
    output cfg_entry_t       entry_c
);

    cfg_entry_t rom_c;

    always_comb begin
        rom_c = '0;
        case (idx)
            5'd0:    rom_c = {8'h01, 16'h0036};
            5'd1:    rom_c = {8'h02, 16'h0010};
            5'd2:    rom_c = {8'h03, 16'h0797};
            5'd3:    rom_c = {8'h04, 16'h0A1F};
            5'd4:    rom_c = {8'h05, 16'h0088};
            5'd5:    rom_c = {8'h06, 16'h0019};
            5'd6:    rom_c = {8'h07, 16'h0002};
            5'd7:    rom_c = {8'h08, 16'h0000};
            5'd8:    rom_c = {8'h09, 16'h0797};
            5'd9:    rom_c = {8'h0A, 16'h8000};
            5'd10:   rom_c = {8'h0B, 16'h0000};
            5'd11:   rom_c = {8'h0C, 16'h0000};
            5'd12:   rom_c = {8'h0D, 16'h0000};
            5'd13:   rom_c = {8'h1E, 16'h4006};
            5'd14:   rom_c = {8'h20, 16'h0000};
            5'd15:   rom_c = {8'h22, 16'h0000};
            5'd16:   rom_c = {8'h23, 16'h0000};
            5'd17:   rom_c = {8'h2B, 16'h0013};
            5'd18:   rom_c = {8'h2C, 16'h009A};
            5'd19:   rom_c = {8'h2D, 16'h0013};
            5'd20:   rom_c = {8'h2E, 16'h0013};
            5'd21:   rom_c = {8'h35, 16'h0010};
            5'd22:   rom_c = {8'h49, 16'h00A8};
            5'd23:   rom_c = {8'hA0, 16'h0000};
            default: rom_c = '0;
        endcase
        entry_c = (32'(idx) < LUT_SIZE) ? rom_c : '0;
    end

endmodule

// File: rtl/camera_config_seq.sv
// Walks the configuration table after sensor power-up, issuing one I2C write per entry
// with bounded retries, a completion timeout and an idle gap between transfers.
module camera_config_seq
    import camera_cfg_pkg::*;
#(
    parameter logic [7:0]  SLAVE_ADDR     = SLAVE_ADDR_DEFAULT,
    parameter int unsigned LUT_SIZE       = 24,
    parameter int unsigned POWERUP_CYCLES = 20000,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             START,
    output logic [31:0]      I2C_DATA,
    output logic             W_R,
    output logic             GO,
    input  logic             END,
    input  logic             ACK,
    output logic             CONFIG_DONE,
    output logic             CONFIG_ERR,
    output logic [IDX_W-1:0] ENTRY_IDX
);

    localparam int unsigned CNT_MAX_A = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > GAP_CYCLES) ? CNT_MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 2);

    cfg_state_e         state;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry;
    logic               xfer_ok;
    cfg_entry_t         rom_entry_c;

    camera_config_rom #(
        .LUT_SIZE (LUT_SIZE)
    ) u_rom (
        .idx     (ENTRY_IDX),
        .entry_c (rom_entry_c)
    );

    // Sequencer state, shared cycle counter and all registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            cnt         <= '0;
            retry       <= '0;
            xfer_ok     <= 1'b0;
            I2C_DATA    <= '0;
            W_R         <= 1'b0;
            GO          <= 1'b0;
            CONFIG_DONE <= 1'b0;
            CONFIG_ERR  <= 1'b0;
            ENTRY_IDX   <= '0;
        end else begin
            W_R <= 1'b0;
            case (state)
                IDLE: begin
                    if (START || (AUTO_START != 0)) begin
                        cnt   <= '0;
                        state <= PWR_WAIT;
                    end
                end
                PWR_WAIT: begin
                    if (cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
                        cnt       <= '0;
                        retry     <= '0;
                        ENTRY_IDX <= '0;
                        state     <= LOAD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                LOAD: begin
                    I2C_DATA <= {SLAVE_ADDR, rom_entry_c};
                    state    <= ISSUE;
                end
                ISSUE: begin
                    GO    <= 1'b1;
                    cnt   <= '0;
                    state <= WAIT_END;
                end
                WAIT_END: begin
                    // The first two cycles may still see END from the previous transfer.
                    if ((cnt >= CNT_W'(2)) && END) begin
                        xfer_ok <= !ACK;
                        GO      <= 1'b0;
                        state   <= CHECK;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        xfer_ok <= 1'b0;
                        GO      <= 1'b0;
                        state   <= CHECK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CHECK: begin
                    cnt <= '0;
                    if (xfer_ok) begin
                        ENTRY_IDX <= ENTRY_IDX + IDX_W'(1);
                        retry     <= '0;
                        state     <= GAP;
                    end else if (retry < RETRY_W'(MAX_RETRY)) begin
                        retry <= retry + RETRY_W'(1);
                        state <= GAP;
                    end else begin
                        CONFIG_ERR  <= 1'b1;
                        CONFIG_DONE <= 1'b1;
                        state       <= DONE;
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                        cnt <= '0;
                        if (ENTRY_IDX == IDX_W'(LUT_SIZE)) begin
                            CONFIG_DONE <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= LOAD;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (START) begin
                        CONFIG_DONE <= 1'b0;
                        CONFIG_ERR  <= 1'b0;
                        cnt         <= '0;
                        state       <= PWR_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_camera_config_seq.sv
// Randomized I2C responder plus a transfer-list reference model for the configuration sequencer.
module tb_camera_config_seq;

    localparam int unsigned PWR   = 16;
    localparam int unsigned LUT   = 4;
    localparam int unsigned RETRY = 3;
    localparam int unsigned TMO   = 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] i2c_data;
    logic        w_r;
    logic        go;
    logic        end_r;
    logic        ack_r;
    logic        cfg_done;
    logic        cfg_err;
    logic [4:0]  entry_idx;

    int checks   = 0;
    int failures = 0;

    // 0: END after random delay with planned NACKs, 1: END never comes, 2: END stuck high
    int resp_mode = 0;
    int plan [4];
    int used [4];
    int hi        = 0;
    int end_delay = 1;
    int e_hit     = -1;

    logic [23:0] lut_ref [4] = '{24'h010036, 24'h020010, 24'h030797, 24'h040A1F};

    logic [31:0] go_log [$];
    int          len_log [$];
    int          cur_len = 0;
    logic        go_prev = 1'b0;

    logic [31:0] exp_q [$];
    logic        exp_err;
    int          exp_idx;

    camera_config_seq #(
        .SLAVE_ADDR     (8'hBA),
        .LUT_SIZE       (LUT),
        .POWERUP_CYCLES (PWR),
        .MAX_RETRY      (RETRY),
        .TIMEOUT_CYCLES (TMO),
        .GAP_CYCLES     (4),
        .AUTO_START     (1)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst_n),
        .START       (start),
        .I2C_DATA    (i2c_data),
        .W_R         (w_r),
        .GO          (go),
        .END         (end_r),
        .ACK         (ack_r),
        .CONFIG_DONE (cfg_done),
        .CONFIG_ERR  (cfg_err),
        .ENTRY_IDX   (entry_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int entry_of(input logic [7:0] r);
        for (int i = 0; i < int'(LUT); i++)
            if (lut_ref[i][23:16] == r) return i;
        return -1;
    endfunction

    // Bit-engine stand-in: answers each GO pulse according to resp_mode and the NACK plan.
    always @(negedge clk) begin
        if (!rst_n) begin
            used  = '{default:0};
            hi    = 0;
            end_r = (resp_mode == 2);
            ack_r = 1'b0;
        end else if (resp_mode == 2) begin
            end_r = 1'b1;
            ack_r = 1'b0;
        end else if (go) begin
            hi++;
            if (resp_mode == 0 && hi == end_delay) begin
                e_hit = entry_of(i2c_data[23:16]);
                end_r = 1'b1;
                ack_r = 1'b0;
                if (e_hit >= 0 && used[e_hit] < plan[e_hit]) begin
                    ack_r = 1'b1;
                    used[e_hit]++;
                end
            end
        end else begin
            end_r     = 1'b0;
            ack_r     = 1'b0;
            hi        = 0;
            end_delay = $urandom_range(1, 12);
        end
    end

    // Transfer monitor: data word at each GO rise and GO-high length of each attempt.
    always @(negedge clk) begin
        if (!rst_n) begin
            go_log.delete();
            len_log.delete();
            cur_len = 0;
            go_prev = 1'b0;
        end else begin
            if (go && !go_prev) begin
                go_log.push_back(i2c_data);
                cur_len = 1;
            end else if (go) begin
                cur_len++;
            end else if (go_prev) begin
                len_log.push_back(cur_len);
            end
            go_prev = go;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected transfer list: each entry is tried once plus once per NACK, capped at RETRY retries.
    task automatic build_model();
        int fails;
        int tries;
        exp_q.delete();
        exp_err = 1'b0;
        exp_idx = int'(LUT);
        for (int i = 0; i < int'(LUT); i++) begin
            fails = (resp_mode == 1) ? 1000 : (resp_mode == 2) ? 0 : plan[i];
            tries = (fails > int'(RETRY)) ? int'(RETRY) + 1 : fails + 1;
            for (int k = 0; k < tries; k++) exp_q.push_back({8'hBA, lut_ref[i]});
            if (fails > int'(RETRY)) begin
                exp_err = 1'b1;
                exp_idx = i;
                break;
            end
        end
    endtask

    task automatic compare_run(input string tag, input int base);
        build_model();
        check({tag, " done"}, 32'(cfg_done), 32'd1);
        check({tag, " err"}, 32'(cfg_err), 32'(exp_err));
        check({tag, " idx"}, 32'(entry_idx), 32'(exp_idx));
        check({tag, " go_count"}, 32'(go_log.size() - base), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && base + k < go_log.size(); k++)
            check($sformatf("%s data%0d", tag, k), go_log[base + k], exp_q[k]);
    endtask

    task automatic check_lens(input string tag, input int exp_len);
        for (int k = 0; k < len_log.size(); k++)
            check($sformatf("%s go_len%0d", tag, k), 32'(len_log[k]), 32'(exp_len));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!cfg_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " finished"}, 32'(cfg_done), 32'd1);
    endtask

    task automatic wait_go(input string tag, input int min_count);
        int n = 0;
        while (!(go && go_log.size() >= min_count) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " go seen"}, 32'(go), 32'd1);
    endtask

    // Edges after release: 1 in IDLE, PWR in PWR_WAIT, then LOAD and ISSUE before GO is high.
    task automatic measure_first_go(input string tag);
        int n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (go) break;
        end
        check(tag, 32'(n), 32'(PWR + 3));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " GO"}, 32'(go), 32'd0);
        check({tag, " I2C_DATA"}, i2c_data, 32'd0);
        check({tag, " CONFIG_DONE"}, 32'(cfg_done), 32'd0);
        check({tag, " CONFIG_ERR"}, 32'(cfg_err), 32'd0);
        check({tag, " ENTRY_IDX"}, 32'(entry_idx), 32'd0);
        check({tag, " W_R"}, 32'(w_r), 32'd0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        start     = 1'b0;
        resp_mode = 0;
        plan      = '{default:0};
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        measure_first_go("first go latency");
        wait_done("all ack", 2000);
        compare_run("all ack", 0);
        check("all ack W_R", 32'(w_r), 32'd0);

        plan = '{0, 1, 0, 0};
        do_reset();
        wait_done("nack once", 2000);
        compare_run("nack once", 0);

        plan = '{0, 0, 100, 0};
        do_reset();
        wait_done("nack always", 2000);
        compare_run("nack always", 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < int'(LUT); i++) plan[i] = $urandom_range(0, 4);
            do_reset();
            wait_done($sformatf("random%0d", r), 3000);
            compare_run($sformatf("random%0d", r), 0);
        end

        resp_mode = 1;
        plan      = '{default:0};
        do_reset();
        wait_done("timeout", 3000);
        compare_run("timeout", 0);
        check("timeout attempts", 32'(len_log.size()), 32'(RETRY + 1));
        check_lens("timeout", int'(TMO));

        resp_mode = 2;
        do_reset();
        wait_go("stuck end", 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("stuck end", 2000);
        compare_run("stuck end", 0);
        check_lens("stuck end", 3);

        base = go_log.size();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("restart done cleared", 32'(cfg_done), 32'd0);
        check("restart err cleared", 32'(cfg_err), 32'd0);
        wait_done("restart", 2000);
        compare_run("restart", base);

        resp_mode = 1;
        do_reset();
        wait_go("midreset", 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midreset");
        resp_mode = 0;
        plan      = '{default:0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        measure_first_go("midreset relaunch latency");
        wait_done("midreset relaunch", 2000);
        compare_run("midreset relaunch", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
